// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, default bus widths
// and the memory responder's FSM state type.
package cpu_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WAIT_WR_LOW
  } mem_state_t;

  // An instruction word carries the opcode in its top three bits.
  function automatic logic [2:0] opcodeOf(input logic [7:0] word);
    return word[7:5];
  endfunction

endpackage

// File: rtl/mem_array.sv
// 2^AW x DW register-file storage with one write port and a combinational
// read port; every word clears on reset.
module mem_array #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU bus: serves rd/wr strobes against an
// internal register file, arbitrates preload and flags protocol violations.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic          data_e,
  input  logic [DW-1:0] data_in,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] data_out,
  output logic          rd_valid,
  output logic          wr_done,
  output logic          err
);

  mem_state_t    r_state;
  mem_state_t    w_nextState;
  logic [DW-1:0] r_dataOut;
  logic          r_rdValid;
  logic          r_wrDone;
  logic          r_err;

  logic          w_firstWr;
  logic          w_commit;
  logic          w_badWr;
  logic          w_collision;
  logic          w_read;
  logic          w_preload;
  logic          w_ldErr;
  logic          w_memWe;
  logic [AW-1:0] w_memWaddr;
  logic [DW-1:0] w_memWdata;
  logic [DW-1:0] w_memRdata;

  // A wr run starts only from IDLE/READ; later cycles of the run sit in WRITE/WAIT_WR_LOW.
  assign w_firstWr   = wr && (r_state == ST_IDLE || r_state == ST_READ);
  assign w_collision = rd && wr;
  assign w_commit    = w_firstWr && data_e && !rd;
  assign w_badWr     = w_firstWr && !data_e;
  assign w_read      = rd && !wr;
  assign w_preload   = ld_en && (r_state == ST_IDLE) && !rd && !wr;
  assign w_ldErr     = ld_en && !w_preload;

  assign w_memWe    = w_commit || w_preload;
  assign w_memWaddr = w_commit ? addr : ld_addr;
  assign w_memWdata = w_commit ? data_in : ld_data;

  mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_memWe),
    .i_waddr (w_memWaddr),
    .i_wdata (w_memWdata),
    .i_raddr (addr),
    .o_rdata (w_memRdata)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_READ: begin
        if (wr) begin
          w_nextState = w_commit ? ST_WRITE : ST_WAIT_WR_LOW;
        end else if (rd) begin
          w_nextState = ST_READ;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_WRITE:       w_nextState = ST_WAIT_WR_LOW;
      ST_WAIT_WR_LOW: w_nextState = wr ? ST_WAIT_WR_LOW : ST_IDLE;
      default:        w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_dataOut <= '0;
      r_rdValid <= 1'b0;
      r_wrDone  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_rdValid <= w_read;
      r_wrDone  <= w_commit;
      if (w_read) begin
        r_dataOut <= w_memRdata;
      end
      if (w_collision || w_badWr || w_ldErr) begin
        r_err <= 1'b1;
      end
    end
  end

  assign data_out = r_dataOut;
  assign rd_valid = r_rdValid;
  assign wr_done  = r_wrDone;
  assign err      = r_err;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the accumulator CPU's instruction/data bus. Receives the `rd`, `wr` and `data_e` strobes from the controller, plus the address from the PC/IR address mux, and serves reads from or commits writes to an internal 2^AW × DW register-file memory. Provides registered read data to the IR/ALU and flags protocol violations. A preload port lets the bench or boot logic fill the memory before the CPU runs.

## Interface
- `AW`, 5: address width. Depth is 2^AW words.
- `DW`, 8: data width. One word holds one instruction: opcode[7:5] and operand[4:0].

- `clk`  in  1: single clock. All logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `addr`  in  AW: bus address. Sampled on every edge where `rd` or `wr` is high.
- `rd`  in  1: read strobe, level-sensitive.
- `wr`  in  1: write strobe.
- `data_e`  in  1: CPU write-data driver enable. A write is legal only if `data_e` is high.
- `data_in`  in  DW: write data from the accumulator.
- `ld_en`  in  1: preload enable.
- `ld_addr`  in  AW: preload address.
- `ld_data`  in  DW: preload data.
- `data_out`  out  DW: registered read data.
- `rd_valid`  out  1: `data_out` holds data for the current `rd` run.
- `wr_done`  out  1: one-cycle pulse after a committed write.
- `err`  out  1: sticky protocol-error flag.

## Operation
- FSM states and transitions:
  - IDLE: default state.
  - READ: entered when `rd`=1 is sampled. Stays while `rd`=1. Returns to IDLE when `rd`=0.
  - WRITE: entered for exactly one cycle after a committed write. Then goes to WAIT_WR_LOW.
  - WAIT_WR_LOW: stays while `wr`=1. Goes to IDLE when `wr`=0.
- Read:
  - On each edge with `rd`=1 and `wr`=0: `data_out` <= mem[`addr`] and `rd_valid` <= 1.
  - `data_out` re-samples every cycle, so an address change during a read is followed with 1-cycle latency.
  - When `rd` is sampled 0: `rd_valid` <= 0 and `data_out` holds its last value.
- Write:
  - Commits only on the first sampled cycle of a `wr` high run, and only when `data_e`=1 and `rd`=0.
  - Commit action: mem[`addr`] <= `data_in`, and `wr_done` pulses high for one cycle.
  - Further cycles of the same run (WAIT_WR_LOW) write nothing.
- Protocol errors: each of the following sets `err`=1 and performs no memory access that cycle.
  - `rd`=1 and `wr`=1 together. `rd_valid` <= 0 in this case.
  - `wr`=1 with `data_e`=0 on the first cycle of the run. The run is consumed: the FSM goes to WAIT_WR_LOW and the write is not retried.
  - `ld_en`=1 while the FSM is not IDLE, or while `rd` or `wr` is 1. The preload is ignored.
- `err` stays set until reset.
- Preload: in IDLE with `rd`=`wr`=0, `ld_en`=1 writes mem[`ld_addr`] <= `ld_data`. `wr_done` does not pulse.
- Same-address read-after-write: a read on the cycle after a commit returns the new data. There is no bypass within the commit cycle, because `rd` and `wr` cannot both be legal in that cycle.
- Addresses wrap naturally at 2^AW. There is no out-of-range case.

## Timing
- Reset values (asynchronous): FSM=IDLE, `data_out`=0, `rd_valid`=0, `wr_done`=0, `err`=0, all memory words=0.
- Read latency is 1 cycle: `rd` high at edge N gives valid `data_out` and `rd_valid` after edge N.
- This fits controller phases 001–011: `rd` rises in phase 1 and `ld_ir` captures in phase 2/3.
- Write: `wr` high at edge N commits at edge N. New contents are visible to a read sampled at edge N+1. `wr_done` is high during cycle N+1.
- Reset asserted mid-read or mid-write: all state returns to reset values immediately. A write on the same edge as reset release is not committed.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
  - `AW`/`DW` defaults.
  - FSM state typedef.
- Sub-module `mem_array`: 2^AW × DW storage with async reset and one write port. The read is combinational, and `mem_responder` registers it. The FSM, error logic and preload arbitration stay in `mem_responder`.

## Test plan
- Reset and preload: reset, then preload addr 3 = 8'hA5. Then `rd`=1, `addr`=3 for 2 cycles -> `data_out`=8'hA5 one cycle after `rd`, `rd_valid`=1. `rd`=0 -> `rd_valid`=0 and `data_out` stays A5.
- Write then read: `wr`=1, `data_e`=1, `addr`=7, `data_in`=8'h3C held for 2 cycles -> exactly one commit and one `wr_done` pulse. A following read of addr 7 -> 8'h3C.
- Illegal write: `wr`=1 with `data_e`=0, `addr`=7, `data_in`=8'hFF -> `err`=1, mem[7] unchanged (3C).
- Collision: `rd`=`wr`=1 at addr 2 -> `err`=1, `rd_valid`=0, mem[2] unchanged.
- Address sweep: `rd` held high while `addr` steps 0..31 with preloaded data mem[i]=i -> `data_out` tracks i with 1-cycle lag, and wraps to 0 after 31.
- Reset mid-op: assert `rst_n`=0 during a `wr` run -> all outputs 0 and mem[addr]=0. `err` is cleared.
